// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
//   state_t   : IDLE / SHIFT / DONE controller states
//   DEF_WIDTH : default operand width
//   sub_bit   : one-bit full subtractor, returns {borrow_out, difference}
package serial_arith_pkg;

    localparam int unsigned DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [1:0] sub_bit(input logic a, input logic b, input logic bi);
        logic dif;
        logic bor;
        dif = a ^ b ^ bi;
        bor = (~a & b) | (~(a ^ b) & bi);
        return {bor, dif};
    endfunction

endpackage

// File: rtl/full_sub.sv
// One-bit full subtractor: d = a - b - bi, bo = borrow out.
//   d  : difference bit
//   bo : borrow out
//   bi : borrow in
//   a  : minuend bit
//   b  : subtrahend bit
module full_sub
    import serial_arith_pkg::*;
(
    output logic d,
    output logic bo,
    input  logic bi,
    input  logic a,
    input  logic b
);

    assign {bo, d} = sub_bit(a, b, bi);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: D = A - B - Bin, one bit per clock, with a borrow
// flop instead of a borrow chain. Valid/ready handshake on both sides.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready high only in IDLE)
//   a, b, bin           : minuend, subtrahend, borrow-in
//   out_valid/out_ready : result handshake (out_valid high only in DONE)
//   d, bout, ovf        : difference, unsigned borrow-out, signed overflow
//   busy                : high while bits are being resolved
module serial_sub
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_PEN  = CW'(WIDTH - 2);

    state_t          state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             bmsb;
    logic             bit_d;
    logic             bit_bo;

    full_sub u_bit (
        .d  (bit_d),
        .bo (bit_bo),
        .bi (br),
        .a  (ra[cnt]),
        .b  (rb[cnt])
    );

    assign in_ready  = (state == IDLE);
    assign busy      = (state == SHIFT);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ra    <= '0;
            rb    <= '0;
            cnt   <= '0;
            br    <= 1'b0;
            bmsb  <= 1'b0;
            d     <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ra    <= a;
                        rb    <= b;
                        br    <= bin;
                        cnt   <= '0;
                        bmsb  <= 1'b0;
                        d     <= '0;
                        bout  <= 1'b0;
                        ovf   <= 1'b0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    d[cnt] <= bit_d;
                    br     <= bit_bo;
                    // Borrow into the MSB, needed for the signed overflow flag.
                    if (cnt == CNT_PEN) begin
                        bmsb <= bit_bo;
                    end
                    if (cnt == CNT_LAST) begin
                        bout  <= bit_bo;
                        ovf   <= bmsb ^ bit_bo;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
module tb_serial_sub;

    localparam int unsigned W = 4;

    typedef struct {
        logic [W-1:0] d;
        logic         bout;
        logic         ovf;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
    logic         busy;

    int   vectors = 0;
    int   miscompares = 0;
    res_t sb[$];

    serial_sub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        res_t r;
        int   ux, uy, sx, sy, sd, ud;
        ux = int'(x);
        uy = int'(y);
        sx = x[W-1] ? ux - (1 << W) : ux;
        sy = y[W-1] ? uy - (1 << W) : uy;
        ud = ux - uy - int'(bi);
        sd = sx - sy - int'(bi);
        r.d    = W'(ud & ((1 << W) - 1));
        r.bout = (ud < 0);
        r.ovf  = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
        return r;
    endfunction

    // Scoreboard: push on a pending accept, pop on a result handshake.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            sb.push_back(model(a, b, bin));
        end
        if (rst_n && out_valid && out_ready) begin
            chk("excl_rdy", {31'b0, in_ready}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                res_t e;
                e = sb.pop_front();
                chk("d",    {{(32-W){1'b0}}, d}, {{(32-W){1'b0}}, e.d});
                chk("bout", {31'b0, bout}, {31'b0, e.bout});
                chk("ovf",  {31'b0, ovf},  {31'b0, e.ovf});
            end
        end
    end

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        int lat;
        @(posedge clk); #1;
        chk("idle_ready", {31'b0, in_ready}, 32'd1);
        a = x; b = y; bin = bi; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(W));
        @(posedge clk); #1;
        chk("ready_after", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        #2;
        chk("rst_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_busy",  {31'b0, busy}, 32'd0);
        chk("rst_d",     {28'b0, d}, 32'd0);
        chk("rst_flags", {30'b0, bout, ovf}, 32'd0);
        #10 rst_n = 1'b1;

        run_op(4'd9, 4'd3, 1'b0);
        run_op(4'd3, 4'd9, 1'b0);
        run_op(4'd0, 4'd0, 1'b1);
        run_op(4'd8, 4'd1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            run_op(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        // Backpressure with ignored operand pulses during SHIFT and DONE.
        @(posedge clk); #1;
        a = 4'd5; b = 4'd2; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        a = 4'd1; b = 4'd1;
        chk("busy_shift", {31'b0, busy}, 32'd1);
        for (int i = 0; i < 20 && !out_valid; i++) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", {31'b0, out_valid}, 32'd1);
            chk("hold_d", {28'b0, d}, 32'd3);
            chk("hold_ready", {31'b0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("no_second_busy", {31'b0, busy}, 32'd0);
        chk("no_second_valid", {31'b0, out_valid}, 32'd0);

        // Reset in the middle of an operation.
        @(posedge clk); #1;
        a = 4'd12; b = 4'd5; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_ready", {31'b0, in_ready}, 32'd1);
        chk("mid_rst_busy",  {31'b0, busy}, 32'd0);
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_d",     {28'b0, d}, 32'd0);
        chk("mid_rst_flags", {30'b0, bout, ovf}, 32'd0);
        #10 rst_n = 1'b1;
        run_op(4'd12, 4'd5, 1'b0);

        @(posedge clk); #1;
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
